// File: rtl/wb_pkg.sv
// Shared Wishbone types and arbiter owner encoding.
package wb_pkg;

  typedef logic [27:0] adr_t;
  typedef logic [31:0] dat_t;
  typedef logic [3:0]  sel_t;

  // Which master currently holds (or is being given) the shared port.
  typedef logic owner_t;

  localparam owner_t ARB_M0 = 1'b0;
  localparam owner_t ARB_M1 = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Watchdog for the two-master Wishbone arbiter: counts stalled busy cycles and
// flags expiry on the last allowed cycle. Disappears entirely when TIMEOUT_CYCLES is 0.
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,     // busy cycle with no slave response
  input  logic clear,   // response seen, grant released or newly taken
  output logic expire
);

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] tmo_cnt;

    // Expiry fires on the cycle the counter reaches its final value.
    assign expire = run & (tmo_cnt == LastCnt);

    // Count waiting cycles; restart on any response, release, or expiry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tmo_cnt <= '0;
      end else if (clear || expire) begin
        tmo_cnt <= '0;
      end else if (run) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end else begin : g_none
    logic unused_wd;
    assign unused_wd = ^{clk, rst, run, clear};
    assign expire    = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone pipelined arbiter. Grant is combinational (no added
// latency) and locked to the owner for as long as its cyc stays high.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic   clk,
  input  logic   rst,
  // master 0 (instruction side)
  input  logic   m0_cyc,
  input  logic   m0_stb,
  input  logic   m0_we,
  input  adr_t   m0_adr,
  input  dat_t   m0_dat_m,
  input  sel_t   m0_sel,
  output logic   m0_stall,
  output logic   m0_ack,
  output logic   m0_err,
  output dat_t   m0_dat_s,
  // master 1 (data side)
  input  logic   m1_cyc,
  input  logic   m1_stb,
  input  logic   m1_we,
  input  adr_t   m1_adr,
  input  dat_t   m1_dat_m,
  input  sel_t   m1_sel,
  output logic   m1_stall,
  output logic   m1_ack,
  output logic   m1_err,
  output dat_t   m1_dat_s,
  // shared slave side
  output logic   s_cyc,
  output logic   s_stb,
  output logic   s_we,
  output adr_t   s_adr,
  output dat_t   s_dat_m,
  output sel_t   s_sel,
  input  logic   s_stall,
  input  logic   s_ack,
  input  logic   s_err,
  input  dat_t   s_dat_s
);

  logic   busy_q, busy_d;
  owner_t owner_q, owner_d;
  owner_t last_q, last_d;

  owner_t gnt;
  logic   gnt_vld;
  logic   owner_cyc;
  logic   locked;
  logic   expire;
  logic   m0_req, m1_req;

  assign m0_req    = m0_cyc & m0_stb;
  assign m1_req    = m1_cyc & m1_stb;
  assign owner_cyc = (owner_q == ARB_M1) ? m1_cyc : m0_cyc;
  assign locked    = busy_q & owner_cyc;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (locked & ~s_ack & ~s_err),
    .clear  (~locked | s_ack | s_err),
    .expire (expire)
  );

  // Effective grant: held owner first, otherwise arbitrate fresh requests.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ARB_M0;
    if (rst) begin
      gnt_vld = 1'b0;
    end else if (locked) begin
      gnt_vld = 1'b1;
      gnt     = owner_q;
    end else if (m0_req && m1_req) begin
      gnt_vld = 1'b1;
      gnt     = ROUND_ROBIN ? ~last_q : ARB_M0;
    end else if (m0_req) begin
      gnt_vld = 1'b1;
      gnt     = ARB_M0;
    end else if (m1_req) begin
      gnt_vld = 1'b1;
      gnt     = ARB_M1;
    end
  end

  // Lock follows the effective grant; a watchdog expiry drops the lock.
  always_comb begin
    busy_d  = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;
    if (gnt_vld) begin
      busy_d  = ~expire;
      owner_d = gnt;
      last_d  = gnt;
    end
  end

  // Arbiter state; last_q resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      owner_q <= ARB_M0;
      last_q  <= ARB_M1;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Route the granted master to the slave and the slave response back to it.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = (gnt == ARB_M1) ? m1_we    : m0_we;
    s_adr    = (gnt == ARB_M1) ? m1_adr   : m0_adr;
    s_dat_m  = (gnt == ARB_M1) ? m1_dat_m : m0_dat_m;
    s_sel    = (gnt == ARB_M1) ? m1_sel   : m0_sel;
    m0_stall = 1'b1;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    if (gnt_vld) begin
      // An expiring transaction is pulled off the bus and answered with err.
      if (!expire) begin
        s_cyc = (gnt == ARB_M1) ? m1_cyc : m0_cyc;
        s_stb = (gnt == ARB_M1) ? m1_stb : m0_stb;
      end
      if (gnt == ARB_M1) begin
        m1_stall = s_stall | expire;
        m1_ack   = s_ack;
        m1_err   = s_err | expire;
      end else begin
        m0_stall = s_stall | expire;
        m0_ack   = s_ack;
        m0_err   = s_err | expire;
      end
    end
  end

  // Read data is broadcast; masters qualify it with ack.
  assign m0_dat_s = s_dat_s;
  assign m1_dat_s = s_dat_s;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2. Three instances share stimulus: a (round-robin),
// b (fixed priority), c (round-robin with an 8-cycle watchdog).
module tb_wb_arbiter2;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  adr_t m0_adr, m1_adr;
  dat_t m0_dat_m, m1_dat_m, s_dat_s;
  sel_t m0_sel, m1_sel;
  logic s_stall, s_ack, s_err;

  logic a_m0_stall, a_m0_ack, a_m0_err, a_m1_stall, a_m1_ack, a_m1_err;
  logic a_s_cyc, a_s_stb, a_s_we;
  adr_t a_s_adr;
  dat_t a_m0_dat_s, a_m1_dat_s, a_s_dat_m;
  sel_t a_s_sel;

  logic b_m0_stall, b_m0_ack, b_m0_err, b_m1_stall, b_m1_ack, b_m1_err;
  logic b_s_cyc, b_s_stb, b_s_we;
  adr_t b_s_adr;
  dat_t b_m0_dat_s, b_m1_dat_s, b_s_dat_m;
  sel_t b_s_sel;

  logic c_m0_stall, c_m0_ack, c_m0_err, c_m1_stall, c_m1_ack, c_m1_err;
  logic c_s_cyc, c_s_stb, c_s_we;
  adr_t c_s_adr;
  dat_t c_m0_dat_s, c_m1_dat_s, c_s_dat_m;
  sel_t c_s_sel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam adr_t A0 = 28'h00000A0;
  localparam adr_t A1 = 28'h0000100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  wb_arbiter2 #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(0)) u_a (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_m(m0_dat_m), .m0_sel(m0_sel), .m0_stall(a_m0_stall), .m0_ack(a_m0_ack),
    .m0_err(a_m0_err), .m0_dat_s(a_m0_dat_s),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_m(m1_dat_m), .m1_sel(m1_sel), .m1_stall(a_m1_stall), .m1_ack(a_m1_ack),
    .m1_err(a_m1_err), .m1_dat_s(a_m1_dat_s),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_adr(a_s_adr),
    .s_dat_m(a_s_dat_m), .s_sel(a_s_sel), .s_stall(s_stall), .s_ack(s_ack),
    .s_err(s_err), .s_dat_s(s_dat_s)
  );

  wb_arbiter2 #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_m(m0_dat_m), .m0_sel(m0_sel), .m0_stall(b_m0_stall), .m0_ack(b_m0_ack),
    .m0_err(b_m0_err), .m0_dat_s(b_m0_dat_s),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_m(m1_dat_m), .m1_sel(m1_sel), .m1_stall(b_m1_stall), .m1_ack(b_m1_ack),
    .m1_err(b_m1_err), .m1_dat_s(b_m1_dat_s),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
    .s_dat_m(b_s_dat_m), .s_sel(b_s_sel), .s_stall(s_stall), .s_ack(s_ack),
    .s_err(s_err), .s_dat_s(s_dat_s)
  );

  wb_arbiter2 #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) u_c (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_m(m0_dat_m), .m0_sel(m0_sel), .m0_stall(c_m0_stall), .m0_ack(c_m0_ack),
    .m0_err(c_m0_err), .m0_dat_s(c_m0_dat_s),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_m(m1_dat_m), .m1_sel(m1_sel), .m1_stall(c_m1_stall), .m1_ack(c_m1_ack),
    .m1_err(c_m1_err), .m1_dat_s(c_m1_dat_s),
    .s_cyc(c_s_cyc), .s_stb(c_s_stb), .s_we(c_s_we), .s_adr(c_s_adr),
    .s_dat_m(c_s_dat_m), .s_sel(c_s_sel), .s_stall(s_stall), .s_ack(s_ack),
    .s_err(s_err), .s_dat_s(s_dat_s)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = A0;
    m0_dat_m = 32'h0; m0_sel = 4'hF;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = A1;
    m1_dat_m = 32'h0; m1_sel = 4'hF;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat_s = 32'h0;

    // Reset: a request is ignored while rst is high.
    #1;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("rst_s_cyc", a_s_cyc, 1'b0);
    chk("rst_m0_stall", a_m0_stall, 1'b1);
    chk("rst_m1_stall", a_m1_stall, 1'b1);
    chk("rst_m0_ack", a_m0_ack, 1'b0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single m1 read, ack two cycles after the request.
    next_cycle();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("rd_s_cyc", a_s_cyc, 1'b1);
    chk("rd_s_adr", a_s_adr, 28'h0000100);
    chk("rd_m1_stall", a_m1_stall, 1'b0);
    chk("rd_m0_stall", a_m0_stall, 1'b1);
    next_cycle();
    m1_stb = 1'b0;
    #1;
    chk("rd_hold_cyc", a_s_cyc, 1'b1);
    chk("rd_hold_stb", a_s_stb, 1'b0);
    next_cycle();
    s_ack = 1'b1; s_dat_s = 32'hDEADBEEF;
    #1;
    chk("rd_m1_ack", a_m1_ack, 1'b1);
    chk("rd_m1_dat", a_m1_dat_s, 32'hDEADBEEF);
    chk("rd_m0_ack", a_m0_ack, 1'b0);
    next_cycle();
    m1_cyc = 1'b0;
    #1;
    chk("rd_late_ack_m0", a_m0_ack, 1'b0);
    chk("rd_late_ack_m1", a_m1_ack, 1'b0);
    chk("rd_idle_cyc", a_s_cyc, 1'b0);
    s_ack = 1'b0;

    // Tie after m1's transaction: m0 first, then m1 in the release cycle.
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("tie1_s_adr", a_s_adr, A0);
    chk("tie1_m1_stall", a_m1_stall, 1'b1);
    chk("tie1_m0_stall", a_m0_stall, 1'b0);
    next_cycle();
    m0_stb = 1'b0;
    #1;
    chk("tie1_lock_adr", a_s_adr, A0);
    next_cycle();
    s_ack = 1'b1;
    #1;
    chk("tie1_m0_ack", a_m0_ack, 1'b1);
    chk("tie1_m1_ack", a_m1_ack, 1'b0);
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0;
    #1;
    chk("handover_adr", a_s_adr, A1);
    chk("handover_cyc", a_s_cyc, 1'b1);
    chk("handover_m1_stall", a_m1_stall, 1'b0);
    next_cycle();
    m1_stb = 1'b0;
    next_cycle();
    s_ack = 1'b1;
    #1;
    chk("handover_m1_ack", a_m1_ack, 1'b1);
    chk("handover_m0_ack", a_m0_ack, 1'b0);
    next_cycle();
    s_ack = 1'b0; m1_cyc = 1'b0;
    #1;
    chk("handover_idle", a_s_cyc, 1'b0);
    // Last grant was m1, so the next tie goes to m0.
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("tie2_s_adr", a_s_adr, A0);
    next_cycle();
    m0_stb = 1'b0;
    next_cycle();
    s_ack = 1'b1;
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    #1;
    chk("tie2_idle", a_s_cyc, 1'b0);
    // Last grant was m0: round-robin now picks m1, fixed priority still m0.
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("tie3_rr_adr", a_s_adr, A1);
    chk("tie3_rr_m0_stall", a_m0_stall, 1'b1);
    chk("tie3_fix_adr", b_s_adr, A0);
    next_cycle();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();

    // Fixed priority: m0 wins three ties in a row.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      #1;
      chk("fix_s_adr", b_s_adr, A0);
      chk("fix_m1_stall", b_m1_stall, 1'b1);
      next_cycle();
      m0_stb = 1'b0;
      next_cycle();
      s_ack = 1'b1;
      #1;
      chk("fix_m0_ack", b_m0_ack, 1'b1);
      next_cycle();
      s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    end
    next_cycle();

    // Grant locking: m0 write held off by s_stall while m1 waits.
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'b0011;
    m0_dat_m = 32'h12345678; s_stall = 1'b1;
    #1;
    chk("lock_s_adr", a_s_adr, A0);
    chk("lock_s_sel", a_s_sel, 4'b0011);
    chk("lock_s_we", a_s_we, 1'b1);
    chk("lock_s_dat", a_s_dat_m, 32'h12345678);
    chk("lock_m0_stall", a_m0_stall, 1'b1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      m1_cyc = 1'b1; m1_stb = 1'b1;
      #1;
      chk("lock_hold_adr", a_s_adr, A0);
      chk("lock_m1_stall", a_m1_stall, 1'b1);
    end
    next_cycle();
    s_stall = 1'b0;
    #1;
    chk("lock_m0_go", a_m0_stall, 1'b0);
    chk("lock_m1_wait", a_m1_stall, 1'b1);
    next_cycle();
    m0_stb = 1'b0; s_ack = 1'b1;
    #1;
    chk("lock_m0_ack", a_m0_ack, 1'b1);
    chk("lock_m1_still", a_m1_stall, 1'b1);
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
    #1;
    chk("lock_rel_adr", a_s_adr, A1);
    chk("lock_rel_m1_stall", a_m1_stall, 1'b0);
    chk("lock_rel_we", a_s_we, 1'b0);
    next_cycle();
    m1_stb = 1'b0;
    next_cycle();
    s_ack = 1'b1;
    next_cycle();
    s_ack = 1'b0; m1_cyc = 1'b0;
    next_cycle();

    // Watchdog: m1 never answered, m0 pending from the next cycle on.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("wd_start_cyc", c_s_cyc, 1'b1);
    next_cycle();
    m1_stb = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("wd_m0_stall", c_m0_stall, 1'b1);
    for (int i = 2; i <= 7; i++) begin
      next_cycle();
      #1;
      chk("wd_no_err", c_m1_err, 1'b0);
      chk("wd_cyc_held", c_s_cyc, 1'b1);
    end
    next_cycle();
    #1;
    chk("wd_m1_err", c_m1_err, 1'b1);
    chk("wd_s_cyc", c_s_cyc, 1'b0);
    chk("wd_m1_ack", c_m1_ack, 1'b0);
    chk("wd_m0_stall_exp", c_m0_stall, 1'b1);
    chk("wd_off_cyc", a_s_cyc, 1'b1);
    chk("wd_off_err", a_m1_err, 1'b0);
    next_cycle();
    m1_cyc = 1'b0;
    #1;
    chk("wd_next_adr", c_s_adr, A0);
    chk("wd_next_cyc", c_s_cyc, 1'b1);
    chk("wd_next_m0_stall", c_m0_stall, 1'b0);
    chk("wd_next_m1_err", c_m1_err, 1'b0);
    next_cycle();
    m0_stb = 1'b0;
    next_cycle();
    s_ack = 1'b1;
    #1;
    chk("wd_m0_ack", c_m0_ack, 1'b1);
    next_cycle();
    s_ack = 1'b0; m0_cyc = 1'b0;
    next_cycle();

    // Asynchronous reset in the middle of an m0 transaction.
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("ar_start_adr", a_s_adr, A0);
    next_cycle();
    m0_stb = 1'b0;
    #1;
    chk("ar_busy_cyc", a_s_cyc, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_s_cyc", a_s_cyc, 1'b0);
    chk("ar_m0_stall", a_m0_stall, 1'b1);
    chk("ar_m1_stall", a_m1_stall, 1'b1);
    chk("ar_m0_ack", a_m0_ack, 1'b0);
    m0_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("ar_tie_adr", a_s_adr, A0);
    chk("ar_tie_m1_stall", a_m1_stall, 1'b1);
    next_cycle();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
